multicycle_control: RTL
=======================

# multicycle_control

Moore-style control FSM and ALU decoder for the multicycle RV32I datapath. It decodes the latched instruction fields and drives every datapath select and write enable, including the 3-bit ALU operation code consumed by the ALU. It also combines the ALU's Zero flag into the PC write enable for branches. It sits between the instruction register and the datapath muxes, register file, memory and ALU.

## Interface
Parameters: none; field widths are fixed by RV32I.

Ports:
- clk_i  in  1  clock; all state changes on rising edge
- rst_i  in  1  synchronous, active-high reset
- Op_i  in  7  instr[6:0] from the instruction register
- Funct3_i  in  3  instr[14:12]
- Funct7b5_i  in  1  instr[30]
- Zero_i  in  1  ALU flag, high when ALU result == 0
- PCWrite_o  out  1  PC register enable
- AdrSrc_o  out  1  memory address mux: 0 = PC, 1 = ALUOut
- MemWrite_o  out  1  data memory write enable
- IRWrite_o  out  1  instruction register and OldPC enable
- ResultSrc_o  out  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA_o  out  2  ALU A mux: 00 = PC, 01 = OldPC, 10 = rs1 (A)
- ALUSrcB_o  out  2  ALU B mux: 00 = rs2 (WriteData), 01 = ImmExt, 10 = constant 4
- ALUControl_o  out  3  ALU operation: 000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt
- ImmSrc_o  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
- RegWrite_o  out  1  register file write enable
- Illegal_o  out  1  one-cycle pulse in Decode for an unsupported opcode

## Operation
- The state register has 11 states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL.
- All outputs are decoded from the state, except two:
  - PCWrite_o = PCUpdate | (Branch & take), where take = Zero_i.
  - ALUControl_o and ImmSrc_o also depend on the opcode and funct fields.
- Outputs per state (signals not listed are 0 / 00):
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target precompute).
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - MEMREAD: ResultSrc=00, AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1.
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - ALUWB: ResultSrc=00, RegWrite=1.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
  - BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
- State transitions:
  - FETCH→DECODE.
  - DECODE by Op_i: 0000011/0100011→MEMADR; 0110011→EXECR; 0010011→EXECI; 1100011→BRANCH; 1101111→JAL; anything else→FETCH with Illegal_o=1.
  - MEMADR: lw→MEMREAD, sw→MEMWRITE.
  - MEMREAD→MEMWB→FETCH.
  - MEMWRITE→FETCH.
  - EXECR, EXECI, JAL→ALUWB→FETCH.
  - BRANCH→FETCH.
- ALU decoder:
  - ALUOp 00→000 (add).
  - ALUOp 01→001 (sub).
  - ALUOp 10, by Funct3_i:
    - 000→001 if Op_i[5] & Funct7b5_i, else 000.
    - 010→101.
    - 110→011.
    - 111→010.
    - any other value→000.
- ImmSrc decode by Op_i: lw and I-type 00; sw 01; branch 10; jal 11; default 00.

## Timing
- Cycles per instruction, all starting in FETCH: lw 5; sw 4; R-type 4; I-type 4; jal 4; branch 3; illegal 2.
- Zero_i is used combinationally in BRANCH only. The PC loads ALUOut (the target computed in DECODE) on the same edge that leaves BRANCH.
- Reset:
  - While rst_i is high, PCWrite_o, IRWrite_o, MemWrite_o, RegWrite_o and Illegal_o are forced to 0.
  - The state register loads FETCH on the edge.
  - The first instruction is fetched on the first edge with rst_i low.
  - Reset asserted mid-instruction aborts it: no write enables assert during or after that cycle, and execution restarts at FETCH.
- Op_i and the funct inputs are stable from DECODE onward, because IRWrite is asserted only in FETCH.

## Configuration
- MC_BNE_EN defined: branch handling depends on Funct3_i.
  - Funct3_i=001 (bne) is supported; in BRANCH, take = ~Zero_i.
  - Funct3_i=000 (beq) uses take = Zero_i.
  - A branch with any other Funct3 goes DECODE→FETCH with Illegal_o=1.
- MC_BNE_EN undefined: only Funct3_i=000 enters BRANCH; any other branch Funct3 is illegal.

## Test plan
- rst_i high for 2 cycles → all write enables 0; after release, cycle 1 shows FETCH outputs (IRWrite=1, PCWrite=1, ALUSrcB=10, ALUControl=000).
- lw (Op=0000011) → state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 and ResultSrc=01 only in cycle 5; ImmSrc=00.
- sub R-type (Op=0110011, Funct3=000, Funct7b5=1) → ALUControl=001 in EXECR, RegWrite in ALUWB; the same fields with Op=0010011 (addi) → ALUControl=000.
- beq with Zero_i=1 → PCWrite=1 in BRANCH; with Zero_i=0 → PCWrite=0; 3 cycles total; ALUControl=001.
- Op=1111111 → Illegal_o pulses in DECODE, next state FETCH, no RegWrite or MemWrite; bne (Funct3=001) with Zero_i=0 → PCWrite=1 when MC_BNE_EN is defined, Illegal_o=1 when it is not.
- rst_i asserted in the MEMWRITE cycle of sw → MemWrite_o=0 in that cycle; next state FETCH.

Source files
------------

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//
// Control unit for the multicycle RV32I datapath. It is a Moore FSM that
// decodes the latched instruction fields and drives every datapath select
// and write enable. It also contains the ALU decoder, which produces the
// 3-bit operation code, and the immediate-format decoder. The ALU Zero flag
// is folded into the PC write enable while a branch is resolving.
//
// Build option:
//   MC_BNE_EN  when defined, bne (funct3 = 001) is executed alongside beq.
//              When undefined, only beq is a legal branch.
//
// Ports:
//   clk_i         clock; all state changes on the rising edge
//   rst_i         synchronous active-high reset
//   Op_i          instr[6:0] opcode
//   Funct3_i      instr[14:12]
//   Funct7b5_i    instr[30]
//   Zero_i        ALU result == 0 flag
//   PCWrite_o     PC register enable
//   AdrSrc_o      memory address mux (0 = PC, 1 = ALUOut)
//   MemWrite_o    data memory write enable
//   IRWrite_o     instruction register / OldPC enable
//   ResultSrc_o   result mux (00 = ALUOut, 01 = Data, 10 = ALUResult)
//   ALUSrcA_o     ALU A mux (00 = PC, 01 = OldPC, 10 = rs1)
//   ALUSrcB_o     ALU B mux (00 = rs2, 01 = ImmExt, 10 = constant 4)
//   ALUControl_o  ALU op (000 add, 001 sub, 010 and, 011 or, 101 slt)
//   ImmSrc_o      immediate format (00 I, 01 S, 10 B, 11 J)
//   RegWrite_o    register file write enable
//   Illegal_o     one-cycle pulse in DECODE for an unsupported instruction
//
// States:
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   FETCH     | read instruction at PC, PC <= PC + 4
//   DECODE    | read registers, precompute branch/jump target in ALUOut
//   MEMADR    | compute load/store address rs1 + imm
//   MEMREAD   | read data memory at ALUOut
//   MEMWB     | write loaded data to rd
//   MEMWRITE  | write rs2 to data memory at ALUOut
//   EXECR     | R-type ALU operation rs1 op rs2
//   EXECI     | I-type ALU operation rs1 op imm
//   ALUWB     | write ALUOut to rd
//   BRANCH    | compare rs1 - rs2, load PC with target if taken
//   JAL       | PC <= target, ALU computes OldPC + 4 for the link value
// ---------------------------------------------------------------------------
module multicycle_control (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [6:0] Op_i,
    input  logic [2:0] Funct3_i,
    input  logic       Funct7b5_i,
    input  logic       Zero_i,
    output logic       PCWrite_o,
    output logic       AdrSrc_o,
    output logic       MemWrite_o,
    output logic       IRWrite_o,
    output logic [1:0] ResultSrc_o,
    output logic [1:0] ALUSrcA_o,
    output logic [1:0] ALUSrcB_o,
    output logic [2:0] ALUControl_o,
    output logic [1:0] ImmSrc_o,
    output logic       RegWrite_o,
    output logic       Illegal_o
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    state_t     state_q;
    state_t     state_d;

    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       illegal;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [2:0] alu_control;
    logic [1:0] imm_src;

    logic       br_funct_ok;
    logic       take;

    // Which branch flavours are legal, and how Zero maps to "taken".
`ifdef MC_BNE_EN
    assign br_funct_ok = (Funct3_i == F3_BEQ) || (Funct3_i == F3_BNE);
    assign take        = (Funct3_i == F3_BNE) ? ~Zero_i : Zero_i;
`else
    assign br_funct_ok = (Funct3_i == F3_BEQ);
    assign take        = Zero_i;
`endif

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next state and state-decoded controls
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        pc_update  = 1'b0;
        branch     = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;

        case (state_q)
            S_FETCH: begin
                adr_src    = 1'b0;
                ir_write   = 1'b1;
                alu_src_a  = 2'b00;
                alu_src_b  = 2'b10;
                alu_op     = 2'b00;
                result_src = 2'b10;
                pc_update  = 1'b1;
                state_d    = S_DECODE;
            end

            S_DECODE: begin
                // OldPC + imm lands in ALUOut for a later branch or jump.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                alu_op    = 2'b00;
                case (Op_i)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BR: begin
                        if (br_funct_ok) begin
                            state_d = S_BRANCH;
                        end else begin
                            state_d = S_FETCH;
                            illegal = 1'b1;
                        end
                    end
                    default: begin
                        state_d = S_FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end

            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b00;
                // Only lw and sw reach here; opcode bit 5 separates them.
                state_d   = Op_i[5] ? S_MEMWRITE : S_MEMREAD;
            end

            S_MEMREAD: begin
                result_src = 2'b00;
                adr_src    = 1'b1;
                state_d    = S_MEMWB;
            end

            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end

            S_MEMWRITE: begin
                result_src = 2'b00;
                adr_src    = 1'b1;
                mem_write  = 1'b1;
                state_d    = S_FETCH;
            end

            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b00;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end

            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end

            S_ALUWB: begin
                result_src = 2'b00;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end

            S_JAL: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                alu_op     = 2'b00;
                result_src = 2'b00;
                pc_update  = 1'b1;
                state_d    = S_ALUWB;
            end

            S_BRANCH: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b00;
                alu_op     = 2'b01;
                result_src = 2'b00;
                branch     = 1'b1;
                state_d    = S_FETCH;
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // ALU decoder
    // -----------------------------------------------------------------------
    always_comb begin
        alu_control = 3'b000;
        case (alu_op)
            2'b00: alu_control = 3'b000;
            2'b01: alu_control = 3'b001;
            2'b10: begin
                case (Funct3_i)
                    // Only R-type (opcode bit 5 set) can encode sub.
                    3'b000:  alu_control = (Op_i[5] & Funct7b5_i) ? 3'b001 : 3'b000;
                    3'b010:  alu_control = 3'b101;
                    3'b110:  alu_control = 3'b011;
                    3'b111:  alu_control = 3'b010;
                    default: alu_control = 3'b000;
                endcase
            end
            default: alu_control = 3'b000;
        endcase
    end

    // -----------------------------------------------------------------------
    // Immediate format decoder
    // -----------------------------------------------------------------------
    always_comb begin
        imm_src = 2'b00;
        case (Op_i)
            OP_LW, OP_I: imm_src = 2'b00;
            OP_SW:       imm_src = 2'b01;
            OP_BR:       imm_src = 2'b10;
            OP_JAL:      imm_src = 2'b11;
            default:     imm_src = 2'b00;
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs. Write enables are masked while reset is held so that an
    // instruction interrupted by reset cannot commit anything in that cycle.
    // -----------------------------------------------------------------------
    assign PCWrite_o    = ~rst_i & (pc_update | (branch & take));
    assign IRWrite_o    = ~rst_i & ir_write;
    assign MemWrite_o   = ~rst_i & mem_write;
    assign RegWrite_o   = ~rst_i & reg_write;
    assign Illegal_o    = ~rst_i & illegal;

    assign AdrSrc_o     = adr_src;
    assign ResultSrc_o  = result_src;
    assign ALUSrcA_o    = alu_src_a;
    assign ALUSrcB_o    = alu_src_b;
    assign ALUControl_o = alu_control;
    assign ImmSrc_o     = imm_src;

endmodule
